// File: rtl/rat_hist_walker.sv
`default_nettype none
// ============================================================================
// Module   : rat_hist_walker
// Purpose  : Rename history buffer that frees superseded mappings on retire
//            and walks youngest-to-oldest on flush to restore the RAT.
// Revision : 1.0
// ============================================================================

package rat_hist_pkg;
    typedef logic [4:0] t_gpr_id;
    typedef logic [6:0] t_prf_id;

    typedef struct packed {
        logic    valid;
        t_prf_id prfid;
    } t_rat_reclaim_pkt;

    typedef struct packed {
        logic    valid;
        t_gpr_id gpr;
        t_prf_id prfid;
    } t_rat_restore_pkt;
endpackage

module rat_hist_walker
    import rat_hist_pkg::*;
#(
    parameter int NUM_ENTRIES = 32,
    parameter int LG          = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_vld_rn1,
    input  t_gpr_id          alloc_gpr_rn1,
    input  t_prf_id          alloc_pdst_rn1,
    input  t_prf_id          alloc_pdst_old_rn1,
    output logic [LG:0]      alloc_hid_rn1,
    output logic             hist_full,
    output logic             rename_stall,
    input  logic             retire_vld_rb0,
    input  logic [LG:0]      retire_hid_rb0,
    input  logic             flush_vld,
    input  logic [LG:0]      flush_hid,
    input  logic             flush_incl,
    output t_rat_reclaim_pkt rat_reclaim_pkt_rb1,
    output t_rat_restore_pkt rat_restore_pkt_rbx,
    output logic             walk_done
);

    // Only gpr and pdst_old ever leave the buffer, so pdst is not stored.
    typedef struct packed {
        t_gpr_id gpr;
        t_prf_id pdst_old;
    } t_hist_entry;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } t_state;

    t_state           state_q, state_d;
    logic [LG:0]      rd_ptr_q, rd_ptr_d;
    logic [LG:0]      wr_ptr_q, wr_ptr_d;
    logic [LG:0]      tgt_q, tgt_d;
    t_rat_reclaim_pkt reclaim_q, reclaim_d;
    t_rat_restore_pkt restore_q, restore_d;
    logic             walk_done_q, walk_done_d;

    t_hist_entry      hist_mem [NUM_ENTRIES];

    logic             empty_w, full_w, walk_active_w;
    logic             alloc_acc_w, retire_acc_w, flush_acc_w, step_w;
    logic [LG:0]      count_w, wr_post_w, flush_tgt_w, walk_tgt_w, walk_last_w;
    t_hist_entry      walk_entry_w;

    assign count_w       = wr_ptr_q - rd_ptr_q;
    assign empty_w       = (rd_ptr_q == wr_ptr_q);
    assign full_w        = (rd_ptr_q[LG-1:0] == wr_ptr_q[LG-1:0]) && (rd_ptr_q[LG] != wr_ptr_q[LG]);
    // The last restore packet is still on the bus while the FSM is already idle.
    assign walk_active_w = (state_q == S_WALK) || restore_q.valid;

    assign hist_full     = full_w;
    assign rename_stall  = full_w || walk_active_w;
    assign alloc_hid_rn1 = wr_ptr_q;

    assign alloc_acc_w   = alloc_vld_rn1 && !rename_stall;
    assign retire_acc_w  = retire_vld_rb0 && !empty_w;
    assign flush_acc_w   = flush_vld && !walk_active_w;

    assign wr_post_w     = wr_ptr_q + (LG+1)'(alloc_acc_w);
    assign flush_tgt_w   = flush_incl ? flush_hid : flush_hid + (LG+1)'(1);
    assign walk_tgt_w    = (state_q == S_WALK) ? tgt_q : flush_tgt_w;
    assign walk_last_w   = ((state_q == S_WALK) ? wr_ptr_q : wr_post_w) - (LG+1)'(1);
    assign step_w        = (state_q == S_WALK) || (flush_acc_w && (wr_post_w != flush_tgt_w));

    // A same-cycle alloc is the youngest entry and has not reached the array yet.
    always_comb begin
        walk_entry_w = hist_mem[walk_last_w[LG-1:0]];
        if ((state_q == S_IDLE) && alloc_acc_w) begin
            walk_entry_w.gpr      = alloc_gpr_rn1;
            walk_entry_w.pdst_old = alloc_pdst_old_rn1;
        end
    end

    always_comb begin
        state_d         = state_q;
        rd_ptr_d        = rd_ptr_q + (LG+1)'(retire_acc_w);
        wr_ptr_d        = wr_post_w;
        tgt_d           = tgt_q;
        reclaim_d       = '0;
        restore_d       = '0;
        walk_done_d     = 1'b0;

        if (retire_acc_w) begin
            reclaim_d.valid = 1'b1;
            reclaim_d.prfid = hist_mem[rd_ptr_q[LG-1:0]].pdst_old;
        end

        if (flush_acc_w && (wr_post_w == flush_tgt_w)) begin
            walk_done_d = 1'b1;
        end

        if (step_w) begin
            restore_d.valid = 1'b1;
            restore_d.gpr   = walk_entry_w.gpr;
            restore_d.prfid = walk_entry_w.pdst_old;
            wr_ptr_d        = walk_last_w;
            tgt_d           = walk_tgt_w;
            if (walk_last_w == walk_tgt_w) begin
                state_d     = S_IDLE;
                walk_done_d = 1'b1;
            end else begin
                state_d     = S_WALK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            tgt_q       <= '0;
            reclaim_q   <= '0;
            restore_q   <= '0;
            walk_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            tgt_q       <= tgt_d;
            reclaim_q   <= reclaim_d;
            restore_q   <= restore_d;
            walk_done_q <= walk_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_acc_w) begin
            hist_mem[wr_ptr_q[LG-1:0]] <= '{gpr: alloc_gpr_rn1, pdst_old: alloc_pdst_old_rn1};
        end
    end

    assign rat_reclaim_pkt_rb1 = reclaim_q;
    assign rat_restore_pkt_rbx = restore_q;
    assign walk_done           = walk_done_q;

    a_alloc_legal: assert property (@(posedge clk) disable iff (reset)
        alloc_vld_rn1 |-> !rename_stall);
    a_alloc_pdst: assert property (@(posedge clk) disable iff (reset)
        alloc_vld_rn1 |-> (alloc_pdst_rn1 != alloc_pdst_old_rn1));
    a_retire_legal: assert property (@(posedge clk) disable iff (reset)
        retire_vld_rb0 |-> (!empty_w && (retire_hid_rb0 == rd_ptr_q)));
    a_flush_idle: assert property (@(posedge clk) disable iff (reset)
        flush_vld |-> !walk_active_w);
    a_flush_range: assert property (@(posedge clk) disable iff (reset)
        flush_vld |-> ((flush_hid - rd_ptr_q) < count_w));
    a_no_cross: assert property (@(posedge clk) disable iff (reset)
        count_w <= (LG+1)'(NUM_ENTRIES));

endmodule
`default_nettype wire
